bg_scene_sequencer: RTL and testbench

BG_SCENE_SEQUENCER -- requirements
Module: bg_scene_sequencer

---
 rtl/bg_scene_sequencer.sv | 196 +++++++++++++++++++
 tb/tb_bg_scene_sequencer.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bg_scene_sequencer.sv
// Background scene sequencer: frame-synchronous selection of one of three background layers.
// Optional SCENE_BLANK_EN macro inserts one blank frame between auto-advanced scenes.
module bg_scene_sequencer (
  input  logic       clk,
  input  logic       reset,
  input  logic       vsync,
  input  logic       cfg_wr,
  input  logic [1:0] cfg_addr,
  input  logic [7:0] cfg_wdata,
  output logic [7:0] cfg_rdata,
  output logic       vga_en,
  output logic [2:0] bg_sel,
  output logic       irq
);

  localparam int unsigned CTRL_W  = 5;
  localparam int unsigned DWELL_W = 8;
  localparam int unsigned MASK_W  = 3;
  localparam int unsigned CNT_W   = 8;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHOW  = 2'd1;
  localparam logic [1:0] BLANK = 2'd2;

  localparam logic [1:0]         NO_SCENE  = 2'd3;
  localparam logic [CTRL_W-1:0]  CTRL_RST  = 5'h00;
  localparam logic [DWELL_W-1:0] DWELL_RST = 8'd60;
  localparam logic [MASK_W-1:0]  MASK_RST  = 3'b111;

  logic                vsync_q;
  logic                frame_tick;
  logic [CTRL_W-1:0]   ctrl_stg, ctrl_act, ctrl_cur;
  logic [DWELL_W-1:0]  dwell_stg, dwell_act, dwell_cur, dwell_min;
  logic [MASK_W-1:0]   mask_stg, mask_act, mask_cur;
  logic [1:0]          state, state_n;
  logic [1:0]          scene, scene_n;
  logic [CNT_W-1:0]    frame_cnt, cnt_n;
  logic [CNT_W:0]      cnt_inc;
  logic                irq_set, irq_clr, irq_n;
  logic                vga_en_n;
  logic [2:0]          bg_sel_n;
  logic                run, auto_mode, loop_en;
  logic [1:0]          man_scene, lowest, nxt;
  logic                wrap;

  // Lowest enabled scene, or NO_SCENE when the mask is empty.
  function automatic logic [1:0] lowest_scene(input logic [MASK_W-1:0] mask);
    if (mask[0])      lowest_scene = 2'd0;
    else if (mask[1]) lowest_scene = 2'd1;
    else if (mask[2]) lowest_scene = 2'd2;
    else              lowest_scene = NO_SCENE;
  endfunction

  // Next enabled scene above cur, wrapping 2->0; falls back to cur itself.
  function automatic logic [1:0] next_scene(input logic [MASK_W-1:0] mask, input logic [1:0] cur);
    logic [3:0] m4;
    logic [2:0] sum;
    m4 = {1'b0, mask};
    next_scene = cur;
    for (int k = 2; k >= 1; k--) begin
      sum = 3'(cur) + 3'(k);
      if (sum >= 3'd3) sum = sum - 3'd3;
      if (m4[sum[1:0]]) next_scene = sum[1:0];
    end
  endfunction

  assign frame_tick = vsync & ~vsync_q;

  // At a tick the staging values are what gets committed, so decisions use them.
  assign ctrl_cur  = frame_tick ? ctrl_stg  : ctrl_act;
  assign dwell_cur = frame_tick ? dwell_stg : dwell_act;
  assign mask_cur  = frame_tick ? mask_stg  : mask_act;

  assign run       = ctrl_cur[0];
  assign auto_mode = ctrl_cur[1];
  assign man_scene = ctrl_cur[3:2];
  assign loop_en   = ctrl_cur[4];
  assign dwell_min = (dwell_cur == '0) ? DWELL_W'(1) : dwell_cur;
  assign cnt_inc   = (CNT_W+1)'(frame_cnt) + (CNT_W+1)'(1);
  assign lowest    = lowest_scene(mask_cur);
  assign nxt       = next_scene(mask_cur, scene);
  assign wrap      = (nxt <= scene);
  assign irq_clr   = cfg_wr && (cfg_addr == 2'd3) && cfg_wdata[0];

  // Next-state and next-output logic.
  always_comb begin
    state_n  = state;
    scene_n  = scene;
    cnt_n    = frame_cnt;
    irq_set  = 1'b0;
    irq_n    = irq;
    vga_en_n = 1'b0;
    bg_sel_n = 3'b000;
    if (frame_tick) begin
      case (state)
        IDLE: begin
          if (run) begin
            state_n = SHOW;
            cnt_n   = '0;
            scene_n = auto_mode ? lowest : man_scene;
          end
        end
        SHOW: begin
          if (!run) begin
            state_n = IDLE;
          end else if (!auto_mode) begin
            if (man_scene != scene) irq_set = 1'b1;
            scene_n = man_scene;
          end else if (mask_cur == '0) begin
            scene_n = NO_SCENE;
          end else if (scene == NO_SCENE) begin
            scene_n = lowest;
            cnt_n   = '0;
          end else if (cnt_inc >= (CNT_W+1)'(dwell_min)) begin
            irq_set = 1'b1;
            cnt_n   = '0;
            if (wrap && !loop_en) begin
              state_n = IDLE;
            end else begin
              scene_n = nxt;
`ifdef SCENE_BLANK_EN
              state_n = BLANK;
`endif
            end
          end else begin
            cnt_n = cnt_inc[CNT_W-1:0];
          end
        end
        BLANK:   state_n = run ? SHOW : IDLE;
        default: state_n = IDLE;
      endcase
    end
    irq_n    = irq_set | (irq & ~irq_clr);
    vga_en_n = (state_n != IDLE);
    if (state_n == SHOW) begin
      case (scene_n)
        2'd0:    bg_sel_n = 3'b001;
        2'd1:    bg_sel_n = 3'b010;
        2'd2:    bg_sel_n = 3'b100;
        default: bg_sel_n = 3'b000;
      endcase
    end
  end

  // State, configuration and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      vsync_q   <= 1'b0;
      ctrl_stg  <= CTRL_RST;
      dwell_stg <= DWELL_RST;
      mask_stg  <= MASK_RST;
      ctrl_act  <= CTRL_RST;
      dwell_act <= DWELL_RST;
      mask_act  <= MASK_RST;
      state     <= IDLE;
      scene     <= 2'd0;
      frame_cnt <= '0;
      irq       <= 1'b0;
      vga_en    <= 1'b0;
      bg_sel    <= 3'b000;
    end else begin
      vsync_q <= vsync;
      if (frame_tick) begin
        ctrl_act  <= ctrl_stg;
        dwell_act <= dwell_stg;
        mask_act  <= mask_stg;
      end
      if (cfg_wr) begin
        case (cfg_addr)
          2'd0:    ctrl_stg  <= cfg_wdata[CTRL_W-1:0];
          2'd1:    dwell_stg <= cfg_wdata;
          2'd2:    mask_stg  <= cfg_wdata[MASK_W-1:0];
          default: ;
        endcase
      end
      state     <= state_n;
      scene     <= scene_n;
      frame_cnt <= cnt_n;
      irq       <= irq_n;
      vga_en    <= vga_en_n;
      bg_sel    <= bg_sel_n;
    end
  end

  // Register readback; STATUS reflects live state.
  always_comb begin
    cfg_rdata = 8'h00;
    case (cfg_addr)
      2'd0:    cfg_rdata = 8'(ctrl_stg);
      2'd1:    cfg_rdata = dwell_stg;
      2'd2:    cfg_rdata = 8'(mask_stg);
      default: cfg_rdata = {2'b00, state, scene, vga_en, irq};
    endcase
  end

endmodule

// File: tb/tb_bg_scene_sequencer.sv
// Self-checking bench for bg_scene_sequencer: directed scenarios plus randomized traffic
// checked against a frame-level behavioural model.
module tb_bg_scene_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       vsync;
  logic       cfg_wr;
  logic [1:0] cfg_addr;
  logic [7:0] cfg_wdata;
  logic [7:0] cfg_rdata;
  logic       vga_en;
  logic [2:0] bg_sel;
  logic       irq;

  int checks = 0;
  int errors = 0;

`ifdef SCENE_BLANK_EN
  localparam bit BLANK_MODEL = 1'b1;
`else
  localparam bit BLANK_MODEL = 1'b0;
`endif

  // Model: mode 0=idle, 1=showing, 2=blank frame; scene 3 means nothing shown.
  int         m_state, m_scene, m_cnt;
  bit         m_irq, m_set;
  logic [4:0] s_ctrl;
  logic [7:0] s_dwell;
  logic [2:0] s_mask;

  always #5 clk = ~clk;

  bg_scene_sequencer dut (
    .clk       (clk),
    .reset     (reset),
    .vsync     (vsync),
    .cfg_wr    (cfg_wr),
    .cfg_addr  (cfg_addr),
    .cfg_wdata (cfg_wdata),
    .cfg_rdata (cfg_rdata),
    .vga_en    (vga_en),
    .bg_sel    (bg_sel),
    .irq       (irq)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_state = 0; m_scene = 0; m_cnt = 0; m_irq = 1'b0; m_set = 1'b0;
    s_ctrl = 5'h00; s_dwell = 8'd60; s_mask = 3'b111;
  endtask

  // One frame boundary, using the configuration committed at this boundary.
  task automatic model_tick();
    int run, aut, man, lp, lowest, dw, nxt;
    bit found;
    run = int'(s_ctrl[0]); aut = int'(s_ctrl[1]); man = int'(s_ctrl[3:2]); lp = int'(s_ctrl[4]);
    lowest = s_mask[0] ? 0 : s_mask[1] ? 1 : s_mask[2] ? 2 : 3;
    dw = (s_dwell == 8'd0) ? 1 : int'(s_dwell);
    m_set = 1'b0;
    if (m_state == 0) begin
      if (run != 0) begin
        m_state = 1; m_cnt = 0;
        m_scene = (aut != 0) ? lowest : man;
      end
    end else if (m_state == 1) begin
      if (run == 0) m_state = 0;
      else if (aut == 0) begin
        if (man != m_scene) m_set = 1'b1;
        m_scene = man;
      end else if (s_mask == 3'b000) m_scene = 3;
      else if (m_scene == 3) begin
        m_scene = lowest; m_cnt = 0;
      end else if (m_cnt + 1 >= dw) begin
        nxt = m_scene; found = 1'b0;
        for (int k = 1; k <= 3; k++) begin
          if (!found && s_mask[(m_scene + k) % 3]) begin
            nxt = (m_scene + k) % 3; found = 1'b1;
          end
        end
        m_set = 1'b1; m_cnt = 0;
        if (nxt <= m_scene && lp == 0) m_state = 0;
        else begin
          m_scene = nxt;
          if (BLANK_MODEL) m_state = 2;
        end
      end else m_cnt = m_cnt + 1;
    end else begin
      m_state = (run != 0) ? 1 : 0;
    end
    if (m_set) m_irq = 1'b1;
  endtask

  task automatic model_write(input logic [1:0] a, input logic [7:0] d);
    case (a)
      2'd0: s_ctrl = d[4:0];
      2'd1: s_dwell = d;
      2'd2: s_mask = d[2:0];
      default: if (d[0] && !m_set) m_irq = 1'b0;
    endcase
  endtask

  function automatic logic [7:0] exp_status();
    return {2'b00, 2'(m_state), 2'(m_scene), (m_state != 0), m_irq};
  endfunction

  function automatic logic [2:0] exp_bg();
    if (m_state == 1 && m_scene < 3) return 3'(1 << m_scene);
    return 3'b000;
  endfunction

  task automatic do_reset();
    reset = 1'b1; vsync = 1'b0; cfg_wr = 1'b0; cfg_addr = 2'd0; cfg_wdata = 8'h00;
    step(); step();
    reset = 1'b0;
    model_reset();
  endtask

  task automatic cfg_write(input logic [1:0] a, input logic [7:0] d);
    cfg_wr = 1'b1; cfg_addr = a; cfg_wdata = d;
    m_set = 1'b0;
    model_write(a, d);
    step();
    cfg_wr = 1'b0;
  endtask

  // vsync high for one cycle (the tick cycle), optional write in that same cycle.
  task automatic frame(input bit wr, input logic [1:0] a, input logic [7:0] d);
    vsync = 1'b1;
    if (wr) begin
      cfg_wr = 1'b1; cfg_addr = a; cfg_wdata = d;
    end
    model_tick();
    if (wr) model_write(a, d);
    step();
    vsync = 1'b0; cfg_wr = 1'b0;
    repeat (3) step();
  endtask

  task automatic test_reset();
    logic [7:0] exp_rd [4];
    exp_rd = '{8'h00, 8'd60, 8'h07, 8'h00};
    do_reset();
    checks++;
    if (vga_en !== 1'b0 || bg_sel !== 3'b000 || irq !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs got vga_en=%b bg_sel=%b irq=%b exp 0 000 0", vga_en, bg_sel, irq);
    end
    for (int a = 0; a < 4; a++) begin
      cfg_addr = 2'(a);
      #1;
      checks++;
      if (cfg_rdata !== exp_rd[a]) begin
        errors++;
        $display("FAIL reset_rdata addr=%0d got=%02h exp=%02h", a, cfg_rdata, exp_rd[a]);
      end
    end
  endtask

  task automatic test_manual();
    do_reset();
    cfg_write(2'd0, 8'h01);
    frame(1'b0, 2'd0, 8'h00);
    checks++;
    if (vga_en !== 1'b1 || bg_sel !== 3'b001 || irq !== 1'b0) begin
      errors++;
      $display("FAIL manual_start got vga_en=%b bg_sel=%b irq=%b exp 1 001 0", vga_en, bg_sel, irq);
    end
    cfg_write(2'd0, 8'h09);
    frame(1'b0, 2'd0, 8'h00);
    checks++;
    if (bg_sel !== 3'b100 || irq !== 1'b1) begin
      errors++;
      $display("FAIL manual_change got bg_sel=%b irq=%b exp 100 1", bg_sel, irq);
    end
    cfg_write(2'd3, 8'h01);
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("FAIL irq_clear got irq=%b exp 0", irq);
    end
    // Scene change at a tick coinciding with a clear: the set must win.
    cfg_write(2'd0, 8'h05);
    frame(1'b1, 2'd3, 8'h01);
    checks++;
    if (irq !== 1'b1 || bg_sel !== 3'b010) begin
      errors++;
      $display("FAIL set_over_clear got irq=%b bg_sel=%b exp 1 010", irq, bg_sel);
    end
  endtask

  task automatic run_sequence(input logic [7:0] ctrl, input string tag);
    logic [2:0] seq [$];
    int n;
    if (BLANK_MODEL) seq = '{3'b001, 3'b001, 3'b000, 3'b100, 3'b100, 3'b000, 3'b001};
    else             seq = '{3'b001, 3'b001, 3'b100, 3'b100, 3'b001};
    do_reset();
    cfg_write(2'd1, 8'd2);
    cfg_write(2'd2, 8'h05);
    cfg_write(2'd0, ctrl);
    n = ctrl[4] ? seq.size() : seq.size() - 1;
    for (int i = 0; i < n; i++) begin
      frame(1'b0, 2'd0, 8'h00);
      checks++;
      if (bg_sel !== seq[i] || irq !== m_irq) begin
        errors++;
        $display("FAIL %s frame=%0d got bg_sel=%b irq=%b exp %b %b", tag, i, bg_sel, irq, seq[i], m_irq);
      end
      cfg_write(2'd3, 8'h01);
    end
    if (!ctrl[4]) begin
      frame(1'b0, 2'd0, 8'h00);
      cfg_addr = 2'd3;
      #1;
      checks++;
      if (vga_en !== 1'b0 || bg_sel !== 3'b000 || irq !== 1'b1 || cfg_rdata[5:4] !== 2'd0) begin
        errors++;
        $display("FAIL %s_stop got vga_en=%b bg_sel=%b irq=%b state=%0d exp 0 000 1 0",
                 tag, vga_en, bg_sel, irq, cfg_rdata[5:4]);
      end
    end
  endtask

  task automatic test_same_cycle();
    do_reset();
    frame(1'b1, 2'd0, 8'h07);
    cfg_addr = 2'd0;
    #1;
    checks++;
    if (vga_en !== 1'b0 || bg_sel !== 3'b000 || cfg_rdata !== 8'h07) begin
      errors++;
      $display("FAIL same_cycle_hold got vga_en=%b bg_sel=%b ctrl=%02h exp 0 000 07", vga_en, bg_sel, cfg_rdata);
    end
    frame(1'b0, 2'd0, 8'h00);
    cfg_addr = 2'd3;
    #1;
    checks++;
    if (vga_en !== 1'b1 || bg_sel !== 3'b001 || cfg_rdata !== 8'h12) begin
      errors++;
      $display("FAIL same_cycle_apply got vga_en=%b bg_sel=%b status=%02h exp 1 001 12", vga_en, bg_sel, cfg_rdata);
    end
    cfg_write(2'd1, 8'd9);
    reset = 1'b1;
    step();
    cfg_addr = 2'd1;
    #1;
    checks++;
    if (vga_en !== 1'b0 || bg_sel !== 3'b000 || irq !== 1'b0 || cfg_rdata !== 8'd60) begin
      errors++;
      $display("FAIL reset_mid_show got vga_en=%b bg_sel=%b irq=%b dwell=%0d exp 0 000 0 60",
               vga_en, bg_sel, irq, cfg_rdata);
    end
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_random();
    int op;
    logic [1:0] a;
    logic [7:0] d;
    do_reset();
    for (int it = 0; it < 300; it++) begin
      op = int'($urandom_range(0, 9));
      a  = 2'($urandom_range(0, 3));
      d  = 8'($urandom);
      if (a == 2'd0) d[0] = ($urandom_range(0, 4) != 0);
      if (a == 2'd1) d = 8'($urandom_range(0, 3));
      if (op <= 2)      cfg_write(a, d);
      else if (op <= 8) frame(1'b0, 2'd0, 8'h00);
      else              frame(1'b1, a, d);
      cfg_addr = 2'd3;
      #1;
      checks++;
      if (vga_en !== (m_state != 0) || bg_sel !== exp_bg() || irq !== m_irq || cfg_rdata !== exp_status()) begin
        errors++;
        $display("FAIL random it=%0d got vga_en=%b bg_sel=%b irq=%b status=%02h exp %b %b %b %02h",
                 it, vga_en, bg_sel, irq, cfg_rdata, (m_state != 0), exp_bg(), m_irq, exp_status());
      end
    end
  endtask

  initial begin
    reset = 1'b1; vsync = 1'b0; cfg_wr = 1'b0; cfg_addr = 2'd0; cfg_wdata = 8'h00;
    model_reset();
    test_reset();
    test_manual();
    run_sequence(8'h13, "auto_loop");
    run_sequence(8'h03, "auto_noloop");
    test_same_cycle();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
